// File: rtl/sfu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sfu_pkg: FP16 field widths, special constants, FSM state and operand classes. Rev 1.0
// ---------------------------------------------------------------------------
package sfu_pkg;

  localparam int FP16_W    = 16;
  localparam int EXP_W     = 5;
  localparam int MANT_W    = 10;
  localparam int FP16_BIAS = 15;

  localparam logic [FP16_W-1:0] FP16_QNAN  = 16'h7E00;
  localparam logic [FP16_W-1:0] FP16_PINF  = 16'h7C00;
  localparam logic [FP16_W-1:0] FP16_PZERO = 16'h0000;
  localparam logic [FP16_W-1:0] FP16_NZERO = 16'h8000;

  // Root bits produced by the core, one per clock.
  localparam int ITER_STEPS = 12;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ITER  = 3'd2,
    S_WRITE = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    CLS_PZERO  = 3'd0,
    CLS_NZERO  = 3'd1,
    CLS_NEG    = 3'd2,
    CLS_PINF   = 3'd3,
    CLS_NAN    = 3'd4,
    CLS_NORMAL = 3'd5
  } fp_class_t;

  // Subnormals are treated as signed zero.
  function automatic fp_class_t fp16_classify(input logic [FP16_W-1:0] x);
    fp_class_t cls;
    cls = CLS_NORMAL;
    if (x[14:10] == '0)
      cls = x[15] ? CLS_NZERO : CLS_PZERO;
    else if (x[14:10] == '1)
      cls = (x[9:0] != '0) ? CLS_NAN : (x[15] ? CLS_NEG : CLS_PINF);
    else if (x[15])
      cls = CLS_NEG;
    return cls;
  endfunction

  function automatic logic [FP16_W-1:0] fp16_special_result(input fp_class_t cls);
    logic [FP16_W-1:0] res;
    case (cls)
      CLS_PZERO: res = FP16_PZERO;
      CLS_NZERO: res = FP16_NZERO;
      CLS_PINF:  res = FP16_PINF;
      default:   res = FP16_QNAN;
    endcase
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp16_sqrt_core.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fp16_sqrt_core: restoring bit-serial square root of a normal FP16 operand. Rev 1.0
// ---------------------------------------------------------------------------
module fp16_sqrt_core
  import sfu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [EXP_W-1:0]  exp_in,
  input  logic [MANT_W-1:0] mant_in,
  output logic              valid,
  output logic [FP16_W-1:0] result
);

  localparam logic [3:0] LAST_STEP = 4'(ITER_STEPS - 1);

  logic        r_active;
  logic [3:0]  r_count;
  logic [23:0] r_rad;
  logic [14:0] r_rem;
  logic [11:0] r_root;
  logic [4:0]  r_exp;

  logic [23:0] w_sig;
  logic [23:0] w_rad_init;
  logic [4:0]  w_exp_init;
  logic [23:0] w_rad;
  logic [14:0] w_rem;
  logic [11:0] w_root;
  logic [14:0] w_rem_sh;
  logic [14:0] w_trial;
  logic        w_ge;
  logic [14:0] w_rem_next;
  logic [11:0] w_root_next;
  logic [11:0] w_sum;
  logic [14:0] w_mag;

  // Even exponents get one extra shift so the halved exponent stays integral.
  assign w_sig      = {13'd0, 1'b1, mant_in};
  assign w_rad_init = exp_in[0] ? (w_sig << 12) : (w_sig << 13);
  assign w_exp_init = 5'(({1'b0, exp_in} + 6'(FP16_BIAS)) >> 1);

  // The first root bit is resolved on the start edge itself.
  assign w_rad  = start ? w_rad_init : r_rad;
  assign w_rem  = start ? '0 : r_rem;
  assign w_root = start ? '0 : r_root;

  assign w_rem_sh    = (w_rem << 2) | {13'd0, w_rad[23:22]};
  assign w_trial     = {1'b0, w_root, 2'b01};
  assign w_ge        = (w_rem_sh >= w_trial);
  assign w_rem_next  = w_ge ? (w_rem_sh - w_trial) : w_rem_sh;
  assign w_root_next = {w_root[10:0], w_ge};

  // Guard-bit rounding; a carry out of the fraction ripples into the exponent field.
  assign w_sum = {1'b0, w_root_next[11:1]} + {11'd0, w_root_next[0]};
  assign w_mag = {r_exp - 5'd1, 10'd0} + {3'd0, w_sum};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_active <= 1'b0;
      r_count  <= '0;
      r_rad    <= '0;
      r_rem    <= '0;
      r_root   <= '0;
      r_exp    <= '0;
      valid    <= 1'b0;
      result   <= '0;
    end else begin
      valid <= 1'b0;
      if (start) begin
        r_active <= 1'b1;
        r_count  <= 4'd1;
        r_rad    <= w_rad << 2;
        r_rem    <= w_rem_next;
        r_root   <= w_root_next;
        r_exp    <= w_exp_init;
      end else if (r_active) begin
        r_count <= r_count + 4'd1;
        r_rad   <= w_rad << 2;
        r_rem   <= w_rem_next;
        r_root  <= w_root_next;
        if (r_count == LAST_STEP) begin
          r_active <= 1'b0;
          valid    <= 1'b1;
          result   <= {1'b0, w_mag};
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/acc_sqrt.sv
`default_nettype none
// ---------------------------------------------------------------------------
// acc_sqrt: in-order FP16 square root over an operand array into a result array. Rev 1.0
// ---------------------------------------------------------------------------
module acc_sqrt
  import sfu_pkg::*;
#(
  parameter int data_width = 16,
  parameter int data_cnt   = 64
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [data_cnt-1:0][data_width-1:0]  array,
  output logic [data_cnt-1:0][data_width-1:0]  rtarray,
  output logic                                 busy,
  output logic                                 done
);

  localparam int IDX_W = (data_cnt > 1) ? $clog2(data_cnt) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(data_cnt - 1);

  state_t            r_state;
  logic [IDX_W-1:0]  r_index;
  logic              r_use_spec;
  logic [FP16_W-1:0] r_spec;

  logic [FP16_W-1:0] w_elem;
  fp_class_t         w_cls;
  logic              w_core_start;
  logic              w_core_valid;
  logic [FP16_W-1:0] w_core_result;

  assign w_elem       = FP16_W'(array[r_index]);
  assign w_cls        = fp16_classify(w_elem);
  assign w_core_start = (r_state == S_LOAD) && (w_cls == CLS_NORMAL);

  fp16_sqrt_core u_core (
    .clk     (clk),
    .rst     (rst),
    .start   (w_core_start),
    .exp_in  (w_elem[14:10]),
    .mant_in (w_elem[9:0]),
    .valid   (w_core_valid),
    .result  (w_core_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_index    <= '0;
      r_use_spec <= 1'b0;
      r_spec     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rtarray    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_LOAD;
            r_index <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end
        S_LOAD: begin
          // Specials bypass the iterative core and finish in two cycles.
          if (w_cls == CLS_NORMAL) begin
            r_use_spec <= 1'b0;
            r_state    <= S_ITER;
          end else begin
            r_use_spec <= 1'b1;
            r_spec     <= fp16_special_result(w_cls);
            r_state    <= S_WRITE;
          end
        end
        S_ITER: begin
          if (w_core_valid)
            r_state <= S_WRITE;
        end
        S_WRITE: begin
          rtarray[r_index] <= data_width'(r_use_spec ? r_spec : w_core_result);
          if (r_index == LAST_IDX) begin
            r_state <= S_FIN;
          end else begin
            r_index <= r_index + IDX_W'(1);
            r_state <= S_LOAD;
          end
        end
        S_FIN: begin
          busy <= 1'b0;
          done <= 1'b1;
          if (start) begin
            r_state <= S_LOAD;
            r_index <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_acc_sqrt.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_acc_sqrt: directed and randomized checks of acc_sqrt against a reference model. Rev 1.0
// ---------------------------------------------------------------------------
module tb_acc_sqrt;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [3:0][15:0] array;
  logic [3:0][15:0] rtarray;
  logic             busy;
  logic             done;

  int vectors    = 0;
  int miscompares = 0;

  logic [3:0][15:0] v;

  acc_sqrt #(.data_width(16), .data_cnt(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .array   (array),
    .rtarray (rtarray),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Square root of an FP16 value: specials by IEEE rules, normals via exact integer sqrt.
  function automatic logic [15:0] model_sqrt(input logic [15:0] x);
    int     e;
    int     m;
    int     ex;
    longint r;
    longint q;
    longint rounded;
    e = int'(x[14:10]);
    m = int'(x[9:0]);
    if (e == 0)            return x[15] ? 16'h8000 : 16'h0000;
    if (e == 31 && m != 0) return 16'h7E00;
    if (x[15])             return 16'h7E00;
    if (e == 31)           return 16'h7C00;
    r = longint'(1024 + m) << (((e % 2) == 1) ? 12 : 13);
    q = longint'($rtoi($sqrt(real'(r))));
    while (q * q > r) q = q - 1;
    while ((q + 1) * (q + 1) <= r) q = q + 1;
    ex = (e + 15) / 2;
    rounded = (q + 1) / 2;
    return 16'((longint'(ex) * 1024) + rounded - 1024);
  endfunction

  function automatic int pass_cycles(input logic [3:0][15:0] a);
    int n;
    n = 1;
    for (int i = 0; i < 4; i++) begin
      if (!a[i][15] && a[i][14:10] != 5'd0 && a[i][14:10] != 5'd31) n += 14;
      else n += 2;
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_pass(input string tag, input logic [3:0][15:0] vals, input int glitch);
    int cycles;
    int exp_cyc;
    exp_cyc = pass_cycles(vals);
    array = vals;
    start = 1'b1;
    tick();
    start = 1'b0;
    check($sformatf("%s_busy_on", tag), 64'(busy), 64'd1);
    check($sformatf("%s_done_drop", tag), 64'(done), 64'd0);
    cycles = 0;
    while (!done && cycles < 300) begin
      start = (cycles == glitch);
      tick();
      cycles++;
    end
    start = 1'b0;
    check($sformatf("%s_latency", tag), 64'(cycles), 64'(exp_cyc));
    check($sformatf("%s_busy_off", tag), 64'(busy), 64'd0);
    for (int i = 0; i < 4; i++)
      check($sformatf("%s_elem%0d(%h)", tag, i, vals[i]), 64'(rtarray[i]), 64'(model_sqrt(vals[i])));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    array = '0;
    repeat (3) tick();
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_rtarray", rtarray, 64'd0);
    rst = 1'b0;
    tick();
    check("idle_done", 64'(done), 64'd0);

    // Normal operands, including the largest finite value.
    v[0] = 16'h4400; v[1] = 16'h4000; v[2] = 16'h3400; v[3] = 16'h7BFF;
    run_pass("normals", v, -1);
    check("normals_const", rtarray, 64'h5BFF_3800_3DA8_4000);
    repeat (3) tick();
    check("done_level", 64'(done), 64'd1);
    check("fin_hold", rtarray, 64'h5BFF_3800_3DA8_4000);

    v[0] = 16'hBC00; v[1] = 16'h7C00; v[2] = 16'h7E01; v[3] = 16'h8000;
    run_pass("specials", v, -1);
    check("specials_const", rtarray, 64'h8000_7E00_7C00_7E00);

    v[0] = 16'h0001; v[1] = 16'h83FF; v[2] = 16'h3C00; v[3] = 16'h0000;
    run_pass("subnorm", v, -1);
    check("subnorm_const", rtarray, 64'h0000_3C00_8000_0000);

    // Reset while element 2 is iterating.
    v[0] = 16'h4400; v[1] = 16'h4000; v[2] = 16'h3400; v[3] = 16'h7BFF;
    array = v;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (33) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midreset_busy", 64'(busy), 64'd0);
    check("midreset_done", 64'(done), 64'd0);
    check("midreset_rtarray", rtarray, 64'd0);
    tick();
    run_pass("after_reset", v, -1);

    // Start pulses while busy must not restart the pass.
    v[0] = 16'h5A3C; v[1] = 16'h0200; v[2] = 16'h2E71; v[3] = 16'h4A00;
    run_pass("glitch_early", v, 5);
    v[0] = 16'h3555; v[1] = 16'h6001; v[2] = 16'h0C00; v[3] = 16'h3BFF;
    run_pass("glitch_late", v, 40);

    for (int p = 0; p < 16; p++) begin
      for (int i = 0; i < 4; i++)
        v[i] = {1'b0, 5'($urandom_range(1, 30)), 10'($urandom_range(0, 1023))};
      run_pass($sformatf("rnd_norm%0d", p), v, -1);
    end
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 4; i++)
        v[i] = 16'($urandom());
      run_pass($sformatf("rnd_any%0d", p), v, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/acc_sqrt.md
ACC_SQRT -- requirements
Module: acc_sqrt

Interface
REQ-001 Parameter data_width, default 16, element width (FP16 only; other values unsupported).
REQ-002 Parameter data_cnt, default 64, elements per array.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  begin pass over array when idle or done.
REQ-006 array  input  data_width x data_cnt  FP16 operands (squared values); held stable while busy.
REQ-007 rtarray  output  data_width x data_cnt  registered FP16 square roots, index-aligned with array.
REQ-008 busy  output  1  high from start acceptance until final write.
REQ-009 done  output  1  level, high after pass completes until next accepted start or reset.

Function
REQ-010 FSM states SHALL be IDLE, LOAD, ITER, WRITE, FIN; reset state IDLE.
REQ-011 IDLE/FIN: start=1 -> LOAD, index=0, busy=1, done=0; start while busy SHALL be ignored.
REQ-012 LOAD SHALL sample array[index], classify: +/-0 or subnormal, negative nonzero, inf, NaN, normal.
REQ-013 Special operands SHALL go LOAD -> WRITE (2 cycles/element): +0/+subnormal -> 16'h0000; -0/-subnormal -> 16'h8000; negative normal/-inf -> 16'h7E00; +inf -> 16'h7C00; any NaN -> 16'h7E00.
REQ-014 Normal operand (E in 1..30): result exponent = (E+15)>>1; radicand R (24-bit) = {1,mant}<<12 when E odd, <<13 when E even.
REQ-015 ITER SHALL run restoring bit-serial square root, 1 root bit/cycle, exactly 12 cycles, giving Q=floor(sqrt(R)) in [2^11,2^12).
REQ-016 Rounding: fraction = Q[10:1] + Q[0] (round-half-up on guard; exact ties impossible); fraction carry SHALL zero the fraction and increment exponent.
REQ-017 Result sign for normal operands SHALL be 0.
REQ-018 WRITE SHALL store result to rtarray[index]; if index==data_cnt-1 -> FIN, else index+1 -> LOAD.
REQ-019 Normal-element latency SHALL be 14 cycles (LOAD 1, ITER 12, WRITE 1).
REQ-020 FIN: busy=0, done=1; rtarray holds values until overwritten by next pass.
REQ-021 Index SHALL never wrap or address beyond data_cnt-1.

Reset
REQ-022 rst=1 on any edge, including mid-pass, SHALL force IDLE, index=0, busy=0, done=0, all rtarray entries 16'h0000, datapath registers cleared.
REQ-023 No partial results SHALL survive reset.

Structure
REQ-024 Shared package sfu_pkg SHALL hold FP16 field widths, bias 15, constants FP16_QNAN=16'h7E00, FP16_PINF=16'h7C00, and the FSM state enum.
REQ-025 Iteration datapath (radicand, remainder, partial root, 4-bit counter, rounding) SHALL be sub-module fp16_sqrt_core with start/valid handshake; acc_sqrt owns FSM, indexing, storage.

Verification
REQ-026 data_cnt=4, array={0x4400,0x4000,0x3400,0x7BFF}, start 1 cycle -> rtarray={0x4000,0x3DA8,0x3800,0x5BFF}, done high exactly 57 cycles after start edge.
REQ-027 array={0xBC00,0x7C00,0x7E01,0x8000} -> {0x7E00,0x7C00,0x7E00,0x8000}, done after 2-cycle/element timing (9 cycles).
REQ-028 array={0x0001,0x83FF,0x3C00,0x0000} -> {0x0000,0x8000,0x3C00,0x0000}.
REQ-029 Assert rst during ITER of element 2 -> next cycle busy=0, done=0, all rtarray=0; subsequent start completes a full correct pass.
REQ-030 start pulsed during busy -> no restart, index monotonic; start in FIN -> new pass, done drops next cycle.
REQ-031 Random normal FP16 sweep vs. reference model sqrt rounded per REQ-016 -> bit-exact match.
